fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Each queue entry pairs an instruction with the PC it was fetched from.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [3:0]  IMEM_RMASK_FULL  = 4'hF;
  localparam logic [3:0]  IMEM_RMASK_IDLE  = 4'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1eceb000;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect, dequeue.
// The master side is the fetch unit; the slave side is memory plus consumer.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;

  modport master (
    output imem_addr, imem_rmask, deq_valid, deq_pc, deq_inst,
    input  imem_rdata, imem_resp, redirect, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_addr, imem_rmask, deq_valid, deq_pc, deq_inst,
    output imem_rdata, imem_resp, redirect, redirect_pc, deq_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue: circular buffer of fetch entries with flush.
// Head is read combinationally so the consumer sees the entry the cycle after it lands.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into the queue, and redirect handling that discards stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam int            CW         = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard_cnt;
  logic [CW-1:0] w_queue_count;
  logic [CW:0]   w_in_use;
  logic          w_issue;
  logic          w_resp;
  logic          w_keep;
  logic          w_deq;
  fetch_entry_t  w_enq_entry;
  fetch_entry_t  w_head;

  // Credit is taken from registered counts only, so a dequeue frees a slot next cycle.
  assign w_in_use = {1'b0, w_queue_count} + {1'b0, r_outstanding};
  assign w_issue  = (w_in_use < CREDIT_MAX) & ~bus.redirect & ~rst;
  assign w_resp   = bus.imem_resp & (r_outstanding != '0);
  assign w_keep   = w_resp & ~bus.redirect & (r_discard_cnt == '0);
  assign w_deq    = bus.deq_valid & bus.deq_ready;

  assign w_enq_entry = '{pc: r_resp_pc, inst: bus.imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp);
      if (bus.redirect) begin
        // Every request still in flight after this cycle belongs to the old stream.
        r_fetch_pc    <= bus.redirect_pc;
        r_resp_pc     <= bus.redirect_pc;
        r_discard_cnt <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_keep) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end else if (w_resp) begin
          r_discard_cnt <= r_discard_cnt - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_keep),
    .i_data  (w_enq_entry),
    .i_pop   (w_deq),
    .i_flush (bus.redirect),
    .o_head  (w_head),
    .o_count (w_queue_count)
  );

  assign bus.imem_addr  = r_fetch_pc;
  assign bus.imem_rmask = w_issue ? IMEM_RMASK_FULL : IMEM_RMASK_IDLE;
  assign bus.deq_valid  = (w_queue_count != '0) & ~bus.redirect;
  assign bus.deq_pc     = w_head.pc;
  assign bus.deq_inst   = w_head.inst;

  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp && (r_outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable in-order memory model
// feeds responses while the linear sequence below checks issue and dequeue streams.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic clk = 1'b0;
  logic rst;

  fetch_if bus ();

  fetch_unit #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [31:0] pend_addr [$];
  int          pend_rdy  [$];
  logic [31:0] issue_log [$];
  logic [31:0] deq_pc_log [$];
  logic [31:0] deq_inst_log [$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("chk %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // One clock: sample issue/dequeue before the edge, then update the memory model.
  task automatic step();
    @(negedge clk);
    if (bus.imem_rmask == IMEM_RMASK_FULL) begin
      pend_addr.push_back(bus.imem_addr);
      pend_rdy.push_back(cyc + lat);
      issue_log.push_back(bus.imem_addr);
    end
    if (bus.deq_valid && bus.deq_ready) begin
      deq_pc_log.push_back(bus.deq_pc);
      deq_inst_log.push_back(bus.deq_inst);
      $display("deq pc=%08h inst=%08h", bus.deq_pc, bus.deq_inst);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.imem_resp && pend_addr.size() != 0) begin
      pend_addr.delete(0);
      pend_rdy.delete(0);
    end
    if (pend_addr.size() != 0 && pend_rdy[0] <= cyc) begin
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = inst_of(pend_addr[0]);
    end else begin
      bus.imem_resp  = 1'b0;
      bus.imem_rdata = '0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect   = 1'b0;
    pend_addr.delete();
    pend_rdy.delete();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    issue_log.delete();
    deq_pc_log.delete();
    deq_inst_log.delete();
    #1;
  endtask

  task automatic chk_deq(input string tag, input int idx, input logic [31:0] pc);
    if (idx < deq_pc_log.size()) begin
      chk($sformatf("%s_pc%0d", tag, idx), deq_pc_log[idx], pc);
      chk($sformatf("%s_inst%0d", tag, idx), deq_inst_log[idx], inst_of(pc));
    end else begin
      chk($sformatf("%s_have%0d", tag, idx), 32'(deq_pc_log.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    bus.redirect_pc = '0;
    bus.deq_ready   = 1'b1;
    do_reset();
    repeat (2) step();

    // Reset state and streaming with latency 1
    chk("rst_rmask", 32'(bus.imem_rmask), 32'h0);
    chk("rst_deq_valid", 32'(bus.deq_valid), 32'h0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    lat = 1;
    release_reset();
    chk("t1_first_rmask", 32'(bus.imem_rmask), 32'hF);
    chk("t1_first_addr", bus.imem_addr, RST_PC);
    repeat (8) step();
    chk("t1_issue_n", 32'(issue_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < issue_log.size(); i++)
      chk($sformatf("t1_issue%0d", i), issue_log[i], RST_PC + 32'(4 * i));
    chk("t1_deq_n", 32'(deq_pc_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_deq("t1", i, RST_PC + 32'(4 * i));

    // Consumer stalled: credit caps the queue at four entries
    do_reset();
    bus.deq_ready = 1'b0;
    step();
    release_reset();
    repeat (20) step();
    chk("t2_issue_n", 32'(issue_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < issue_log.size(); i++)
      chk($sformatf("t2_issue%0d", i), issue_log[i], RST_PC + 32'(4 * i));
    chk("t2_full_rmask", 32'(bus.imem_rmask), 32'h0);
    chk("t2_count", 32'(dut.w_queue_count), 32'd4);
    chk("t2_head_pc", bus.deq_pc, RST_PC);
    chk("t2_head_inst", bus.deq_inst, inst_of(RST_PC));
    issue_log.delete();
    bus.deq_ready = 1'b1;
    #1;
    chk("t2_no_comb_credit", 32'(bus.imem_rmask), 32'h0);
    step();
    chk("t2_resume_rmask", 32'(bus.imem_rmask), 32'hF);
    chk("t2_resume_addr", bus.imem_addr, RST_PC + 32'h10);
    repeat (7) step();
    chk("t2_deq_n", 32'(deq_pc_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_deq("t2", i, RST_PC + 32'(4 * i));

    // Latency 5, redirect with three requests in flight
    do_reset();
    lat = 5;
    step();
    release_reset();
    repeat (3) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h1eceb100;
    #1;
    chk("t3_redir_rmask", 32'(bus.imem_rmask), 32'h0);
    chk("t3_redir_deq_valid", 32'(bus.deq_valid), 32'h0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("t3_discard", 32'(dut.r_discard_cnt), 32'd3);
    chk("t3_resume_rmask", 32'(bus.imem_rmask), 32'hF);
    chk("t3_resume_addr", bus.imem_addr, 32'h1eceb100);
    repeat (12) step();
    chk_deq("t3", 0, 32'h1eceb100);
    chk_deq("t3", 1, 32'h1eceb104);

    // Redirect coinciding with a response and a dequeue handshake
    do_reset();
    lat = 2;
    step();
    release_reset();
    repeat (3) step();
    chk("t4_pre_deq_valid", 32'(bus.deq_valid), 32'h1);
    chk("t4_pre_resp", 32'(bus.imem_resp), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h1eceb300;
    #1;
    chk("t4_redir_deq_valid", 32'(bus.deq_valid), 32'h0);
    chk("t4_redir_rmask", 32'(bus.imem_rmask), 32'h0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("t4_discard", 32'(dut.r_discard_cnt), 32'd1);
    chk("t4_outstanding", 32'(dut.r_outstanding), 32'd1);
    chk("t4_issue_while_discard", 32'(bus.imem_rmask), 32'hF);
    chk("t4_resume_addr", bus.imem_addr, 32'h1eceb300);
    repeat (6) step();
    chk_deq("t4", 0, 32'h1eceb300);

    // Back-to-back redirects: the second one wins
    do_reset();
    lat = 3;
    step();
    release_reset();
    repeat (2) step();
    issue_log.delete();
    deq_pc_log.delete();
    deq_inst_log.delete();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h1eceb100;
    #1;
    chk("t5_redir1_rmask", 32'(bus.imem_rmask), 32'h0);
    step();
    bus.redirect_pc = 32'h1eceb200;
    #1;
    chk("t5_redir2_rmask", 32'(bus.imem_rmask), 32'h0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("t5_discard", 32'(dut.r_discard_cnt), 32'd1);
    chk("t5_resume_addr", bus.imem_addr, 32'h1eceb200);
    repeat (6) step();
    if (issue_log.size() != 0) chk("t5_first_issue", issue_log[0], 32'h1eceb200);
    else chk("t5_issue_n", 32'(issue_log.size()), 32'd1);
    chk_deq("t5", 0, 32'h1eceb200);

    // Reset asserted mid-operation with requests in flight and a loaded queue
    do_reset();
    lat = 3;
    bus.deq_ready = 1'b0;
    step();
    release_reset();
    repeat (5) step();
    chk("t6_pre_count", 32'(dut.w_queue_count), 32'd2);
    chk("t6_pre_outstanding", 32'(dut.r_outstanding), 32'd2);
    do_reset();
    #1;
    chk("t6_rst_rmask", 32'(bus.imem_rmask), 32'h0);
    chk("t6_rst_deq_valid", 32'(bus.deq_valid), 32'h0);
    chk("t6_rst_addr", bus.imem_addr, RST_PC);
    repeat (2) step();
    bus.deq_ready = 1'b1;
    release_reset();
    chk("t6_first_rmask", 32'(bus.imem_rmask), 32'hF);
    chk("t6_first_addr", bus.imem_addr, RST_PC);
    repeat (6) step();
    chk_deq("t6", 0, RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
